// File: rtl/dispense_sequencer_if.sv
// Handshake bundle between the recipe host and the dispense sequencer.
// The host drives pacing, start/abort and round counts; the sequencer drives the motor controls.
interface dispense_sequencer_if #(
  parameter int CNT_W = 10
);
  logic             tick;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] r_rounds;
  logic [CNT_W-1:0] y_rounds;
  logic [CNT_W-1:0] b_rounds;
  logic             en_r;
  logic             en_y;
  logic             en_b;
  logic             en_c;
  logic             dir;
  logic             busy;
  logic             done;
  logic [2:0]       phase;

  modport master (
    output tick, start, abort, r_rounds, y_rounds, b_rounds,
    input  en_r, en_y, en_b, en_c, dir, busy, done, phase
  );

  modport slave (
    input  tick, start, abort, r_rounds, y_rounds, b_rounds,
    output en_r, en_y, en_b, en_c, dir, busy, done, phase
  );
endinterface

// File: rtl/dispense_sequencer.sv
// Three-colour dispense sequencer: drop rounds per colour, carriage moves between colours,
// return home with a single done pulse. All timing advances on the external tick strobe.
module dispense_sequencer #(
  parameter int CNT_W = 10,
  parameter int DEPTH = 5,
  parameter int MOVE  = 2
) (
  input  logic               clk,
  input  logic               rst,
  dispense_sequencer_if.slave bus
);

  // state  | meaning
  // IDLE   | waiting for start
  // R_DROP | red drop motor running
  // R_TO_Y | carriage forward red -> yellow
  // Y_DROP | yellow drop motor running
  // Y_TO_B | carriage forward yellow -> blue
  // B_DROP | blue drop motor running
  // B_TO_R | carriage returning home
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    R_DROP = 3'd1,
    R_TO_Y = 3'd2,
    Y_DROP = 3'd3,
    Y_TO_B = 3'd4,
    B_DROP = 3'd5,
    B_TO_R = 3'd6
  } state_e;

  localparam logic [3:0] DROP_LAST = 4'(DEPTH - 1);
  localparam logic [3:0] MOVE_LAST = 4'(MOVE - 1);
  localparam logic [3:0] RET_LAST  = 4'(2 * MOVE - 1);

  state_e           state_q, state_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] rnd_cnt_q, rnd_cnt_d;
  logic [CNT_W-1:0] r_q, r_d, y_q, y_d, b_q, b_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rnd_inc;
  logic [CNT_W-1:0] cur_rounds;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      rnd_cnt_q  <= '0;
      r_q        <= '0;
      y_q        <= '0;
      b_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      rnd_cnt_q  <= rnd_cnt_d;
      r_q        <= r_d;
      y_q        <= y_d;
      b_q        <= b_d;
      done_q     <= done_d;
    end
  end

  assign rnd_inc = rnd_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    rnd_cnt_d  = rnd_cnt_q;
    r_d        = r_q;
    y_d        = y_q;
    b_d        = b_q;
    done_d     = 1'b0;
    cur_rounds = b_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          r_d     = bus.r_rounds;
          y_d     = bus.y_rounds;
          b_d     = bus.b_rounds;
          state_d = (bus.r_rounds == '0) ? R_TO_Y : R_DROP;
        end
      end
      R_DROP, Y_DROP, B_DROP: begin
        if (state_q == R_DROP)      cur_rounds = r_q;
        else if (state_q == Y_DROP) cur_rounds = y_q;
        if (bus.tick) begin
          if (tick_cnt_q == DROP_LAST) begin
            tick_cnt_d = '0;
            rnd_cnt_d  = rnd_inc;
            if (rnd_inc == cur_rounds) begin
              if (state_q == R_DROP)      state_d = R_TO_Y;
              else if (state_q == Y_DROP) state_d = Y_TO_B;
              else                        state_d = B_TO_R;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      R_TO_Y, Y_TO_B: begin
        if (bus.tick) begin
          if (tick_cnt_q == MOVE_LAST) begin
            // a zero-count colour skips straight to the next carriage move
            if (state_q == R_TO_Y) state_d = (y_q == '0) ? Y_TO_B : Y_DROP;
            else                   state_d = (b_q == '0) ? B_TO_R : B_DROP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      B_TO_R: begin
        if (bus.tick) begin
          if (tick_cnt_q == RET_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      tick_cnt_d = '0;
      rnd_cnt_d  = '0;
    end

    if (bus.abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      tick_cnt_d = '0;
      rnd_cnt_d  = '0;
      done_d     = 1'b0;
    end
  end

  assign bus.en_r  = (state_q == R_DROP);
  assign bus.en_y  = (state_q == Y_DROP);
  assign bus.en_b  = (state_q == B_DROP);
  assign bus.en_c  = (state_q == R_TO_Y) || (state_q == Y_TO_B) || (state_q == B_TO_R);
  assign bus.dir   = (state_q == B_TO_R);
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.phase = state_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: each recipe is expanded into the per-tick phase list it must
// produce, and the DUT is compared against that list on every cycle plus directed end checks.
module tb_dispense_sequencer;
  localparam int CNT_W = 10;
  localparam int DEPTH = 5;
  localparam int MOVE  = 2;
  localparam int BIG   = 1 << 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispense_sequencer_if #(.CNT_W(CNT_W)) bus();

  dispense_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH), .MOVE(MOVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: phase expected while each successive tick of the recipe is pending
  int seq[$];
  bit active   = 1'b0;
  int ptr      = 0;
  bit exp_done = 1'b0;

  int ticks, cycles, done_ticks, done_cycles;
  int en_ticks[4];
  int ptrace[$];
  int last_ph = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(int r, int y, int b);
    seq.delete();
    repeat (r * DEPTH)  seq.push_back(1);
    repeat (MOVE)       seq.push_back(2);
    repeat (y * DEPTH)  seq.push_back(3);
    repeat (MOVE)       seq.push_back(4);
    repeat (b * DEPTH)  seq.push_back(5);
    repeat (2 * MOVE)   seq.push_back(6);
  endtask

  // {en_r, en_y, en_b, en_c, dir, busy} for a given phase
  function automatic logic [5:0] exp_outs(int ph);
    logic [5:0] v;
    v[5] = (ph == 1);
    v[4] = (ph == 3);
    v[3] = (ph == 5);
    v[2] = (ph == 2) || (ph == 4) || (ph == 6);
    v[1] = (ph == 6);
    v[0] = (ph != 0);
    return v;
  endfunction

  task automatic cyc(bit t, bit s, bit a, bit r_);
    int ph;
    bus.tick  = t;
    bus.start = s;
    bus.abort = a;
    rst       = r_;
    if (t) begin
      en_ticks[0] += int'(bus.en_r);
      en_ticks[1] += int'(bus.en_y);
      en_ticks[2] += int'(bus.en_b);
      en_ticks[3] += int'(bus.en_c);
    end
    @(posedge clk);
    exp_done = 1'b0;
    if (t) ticks++;
    cycles++;
    if (r_) begin
      active = 1'b0;
    end else if (active) begin
      if (a) begin
        active = 1'b0;
      end else if (t) begin
        ptr++;
        if (ptr == seq.size()) begin
          active   = 1'b0;
          exp_done = 1'b1;
        end
      end
    end else if (s && !a) begin
      build(int'(bus.r_rounds), int'(bus.y_rounds), int'(bus.b_rounds));
      active      = 1'b1;
      ptr         = 0;
      ticks       = 0;
      cycles      = 0;
      done_ticks  = -1;
      done_cycles = -1;
      foreach (en_ticks[i]) en_ticks[i] = 0;
    end
    #1;
    ph = active ? seq[ptr] : 0;
    chk("phase", 32'(bus.phase), 32'(ph));
    chk("outs", 32'({bus.en_r, bus.en_y, bus.en_b, bus.en_c, bus.dir, bus.busy}), 32'(exp_outs(ph)));
    chk("done", 32'(bus.done), 32'(exp_done));
    if (bus.done === 1'b1) begin
      done_ticks  = ticks;
      done_cycles = cycles;
    end
    if (int'(bus.phase) != last_ph) begin
      last_ph = int'(bus.phase);
      ptrace.push_back(last_ph);
    end
  endtask

  // period 0 = random tick, otherwise one tick every 'period' cycles
  task automatic go(int period, int stop_ptr);
    int n;
    bit t;
    n = 0;
    while (active && (ptr < stop_ptr) && (n < 4000)) begin
      if (period == 0) t = 1'($urandom_range(0, 1));
      else             t = ((n % period) == (period - 1));
      cyc(t, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 4000) begin
      total++;
      bad++;
      $error("FAIL go_timeout observed=%0d expected<4000", n);
    end
  endtask

  task automatic start_rec(int r, int y, int b, bit t);
    bus.r_rounds = CNT_W'(r);
    bus.y_rounds = CNT_W'(y);
    bus.b_rounds = CNT_W'(b);
    cyc(t, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic finish_checks(int r, int y, int b);
    chk("done_ticks", 32'(done_ticks), 32'((r + y + b) * DEPTH + 4 * MOVE));
    chk("en_r_ticks", 32'(en_ticks[0]), 32'(r * DEPTH));
    chk("en_y_ticks", 32'(en_ticks[1]), 32'(y * DEPTH));
    chk("en_b_ticks", 32'(en_ticks[2]), 32'(b * DEPTH));
    chk("en_c_ticks", 32'(en_ticks[3]), 32'(4 * MOVE));
  endtask

  initial begin
    int exp_tr[5];
    int r, y, b, p;
    exp_tr = '{2, 3, 4, 6, 0};
    bus.tick = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.r_rounds = '0; bus.y_rounds = '0; bus.b_rounds = '0;
    rst = 1'b1;
    ticks = 0; cycles = 0; done_ticks = -1; done_cycles = -1;
    foreach (en_ticks[i]) en_ticks[i] = 0;

    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // start together with abort in IDLE is ignored
    bus.r_rounds = 10'd1; bus.y_rounds = 10'd1; bus.b_rounds = 10'd1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // nominal 2/4/7, tick every 4 cycles
    start_rec(2, 4, 7, 1'b0);
    go(4, BIG);
    chk("nominal_done_ticks", 32'(done_ticks), 32'd73);
    chk("nominal_en_r", 32'(en_ticks[0]), 32'd10);
    chk("nominal_en_y", 32'(en_ticks[1]), 32'd20);
    chk("nominal_en_b", 32'(en_ticks[2]), 32'd35);
    chk("nominal_en_c", 32'(en_ticks[3]), 32'd8);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // zero-round skip 0/1/0
    ptrace.delete();
    start_rec(0, 1, 0, 1'b0);
    go(3, BIG);
    chk("skip_done_ticks", 32'(done_ticks), 32'd13);
    chk("skip_en_r", 32'(en_ticks[0]), 32'd0);
    chk("skip_en_b", 32'(en_ticks[2]), 32'd0);
    chk("skip_trace_len", 32'(ptrace.size()), 32'd5);
    for (int i = 0; i < 5 && i < ptrace.size(); i++)
      chk("skip_trace", 32'(ptrace[i]), 32'(exp_tr[i]));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // abort in Y_DROP during the second round
    start_rec(1, 3, 1, 1'b0);
    go(2, DEPTH + MOVE + DEPTH + 1);
    chk("abort_pre_phase", 32'(bus.phase), 32'd3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 40; i++) cyc(i[0], 1'b0, 1'b0, 1'b0);
    chk("abort_no_done", 32'(done_ticks), 32'hFFFF_FFFF);

    // start while busy in B_DROP has no effect
    start_rec(1, 1, 2, 1'b0);
    go(2, 2 * DEPTH + 2 * MOVE + 1);
    chk("busy_pre_phase", 32'(bus.phase), 32'd5);
    bus.r_rounds = 10'd3; bus.y_rounds = 10'd3; bus.b_rounds = 10'd3;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    go(2, BIG);
    finish_checks(1, 1, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // reset during R_TO_Y, then a clean 1/1/1 recipe
    start_rec(1, 1, 1, 1'b0);
    go(2, DEPTH + 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    start_rec(1, 1, 1, 1'b0);
    go(2, BIG);
    chk("after_rst_done_ticks", 32'(done_ticks), 32'd23);

    // tick held high; start issued in the done cycle
    start_rec(1, 1, 1, 1'b1);
    go(1, BIG);
    chk("tick_high_cycles", 32'(done_cycles), 32'd23);

    // random back-to-back recipes
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 3);
      y = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      p = $urandom_range(0, 3);
      start_rec(r, y, b, 1'($urandom_range(0, 1)));
      go(p, BIG);
      finish_checks(r, y, b);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
